// File: rtl/vga_pkg.sv
// Shared timing constants and pipeline types for the VGA frame scanner.
package vga_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

  // Image-memory address width and the counter width that covers H_TOT/V_TOT.
  localparam int ADDR_W = 19;
  localparam int CNT_W  = 10;

  // One slot of the control delay line that travels alongside the pixel data.
  typedef struct packed {
    logic vis;
    logic hs_n;
    logic vs_n;
    logic show;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1, show: 1'b0};

endpackage

// File: rtl/vga_sync_counter.sv
// Stage-0 raster counters and the timing decodes derived from them.
module vga_sync_counter #(
  parameter int H_VIS  = vga_pkg::H_VIS,
  parameter int H_FP   = vga_pkg::H_FP,
  parameter int H_SYNC = vga_pkg::H_SYNC,
  parameter int H_BP   = vga_pkg::H_BP,
  parameter int V_VIS  = vga_pkg::V_VIS,
  parameter int V_FP   = vga_pkg::V_FP,
  parameter int V_SYNC = vga_pkg::V_SYNC,
  parameter int V_BP   = vga_pkg::V_BP
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  output logic [vga_pkg::CNT_W-1:0] hcount_o,
  output logic [vga_pkg::CNT_W-1:0] vcount_o,
  output logic                      visible_o,
  output logic                      hs_n_o,
  output logic                      vs_n_o,
  output logic                      frame_start_o
);
  import vga_pkg::*;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VIS + V_FP + V_SYNC);

  logic [CNT_W-1:0] hcount_q, hcount_d;
  logic [CNT_W-1:0] vcount_q, vcount_d;
  // Low while in reset and for the one clock after it; keeps (0,0) from being counted twice.
  logic             active_q;

  // Next raster position: hold while idle, otherwise step with line and frame wrap.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (active_q) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) vcount_d = '0;
        else                    vcount_d = vcount_q + CNT_W'(1);
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
    end
  end

  // Counter registers; the frame restarts at (0,0) on the first clock after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hcount_q <= '0;
      vcount_q <= '0;
      active_q <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      active_q <= 1'b1;
    end
  end

  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign visible_o     = active_q && (hcount_q < H_VIS_C) && (vcount_q < V_VIS_C);
  assign hs_n_o        = !((hcount_q >= HS_BEG) && (hcount_q < HS_END));
  assign vs_n_o        = !((vcount_q >= VS_BEG) && (vcount_q < VS_END));
  assign frame_start_o = active_q && (hcount_q == '0) && (vcount_q == '0);

endmodule

// File: rtl/vga_frame_scanner.sv
// VGA scan-out of the filtered image: window addressing, memory-latency alignment and colour mux.
module vga_frame_scanner #(
  parameter int         H_VIS  = vga_pkg::H_VIS,
  parameter int         H_FP   = vga_pkg::H_FP,
  parameter int         H_SYNC = vga_pkg::H_SYNC,
  parameter int         H_BP   = vga_pkg::H_BP,
  parameter int         V_VIS  = vga_pkg::V_VIS,
  parameter int         V_FP   = vga_pkg::V_FP,
  parameter int         V_SYNC = vga_pkg::V_SYNC,
  parameter int         V_BP   = vga_pkg::V_BP,
  parameter int         IMG_W  = 320,
  parameter int         IMG_H  = 240,
  parameter int         X0     = 160,
  parameter int         Y0     = 120,
  parameter int         RD_LAT = 1,
  parameter logic [7:0] BORDER = 8'h00
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_ready,
  output logic [vga_pkg::ADDR_W-1:0] pix_addr,
  input  logic [7:0]                 pix_data,
  output logic                       vga_hs,
  output logic                       vga_vs,
  output logic                       vga_blank,
  output logic                       vga_clock,
  output logic [7:0]                 r_out,
  output logic [7:0]                 g_out,
  output logic [7:0]                 b_out,
  output logic                       frame_start
);
  import vga_pkg::*;

  localparam int               COL_W  = $clog2(IMG_W + 1);
  localparam logic [CNT_W-1:0] WIN_X0 = CNT_W'(X0);
  localparam logic [CNT_W-1:0] WIN_X1 = CNT_W'(X0 + IMG_W);
  localparam logic [CNT_W-1:0] WIN_XL = CNT_W'(X0 + IMG_W - 1);
  localparam logic [CNT_W-1:0] WIN_Y0 = CNT_W'(Y0);
  localparam logic [CNT_W-1:0] WIN_Y1 = CNT_W'(Y0 + IMG_H);

  logic [CNT_W-1:0]  hcount, vcount;
  logic              visible, hs_n, vs_n, fs;
  logic              in_win, ready_eff;
  stage_t            stage0;

  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  stage_t            dl_q [RD_LAT+1];
  logic              hs_q, vs_q, blank_q;
  logic [7:0]        grey_q, grey_d;

  vga_sync_counter #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_sync (
    .clk_i         (clk),
    .reset_i       (reset),
    .hcount_o      (hcount),
    .vcount_o      (vcount),
    .visible_o     (visible),
    .hs_n_o        (hs_n),
    .vs_n_o        (vs_n),
    .frame_start_o (fs)
  );

  // The latch only changes at frame start, so the new ready applies from the frame's first pixel.
  assign in_win    = visible && (hcount >= WIN_X0) && (hcount < WIN_X1)
                             && (vcount >= WIN_Y0) && (vcount < WIN_Y1);
  assign ready_eff = fs ? frame_ready : ready_q;
  assign stage0    = '{vis: visible, hs_n: hs_n, vs_n: vs_n, show: in_win && ready_eff};

  // Incremental row-major address: column offset plus a row base stepped by IMG_W per window line.
  always_comb begin
    ready_d    = ready_eff;
    row_base_d = row_base_q;
    col_d      = col_q;
    pix_addr_d = pix_addr_q;
    if (fs) begin
      row_base_d = '0;
      col_d      = '0;
    end
    if (in_win) begin
      pix_addr_d = row_base_q + ADDR_W'(col_q);
      if (hcount == WIN_XL) begin
        col_d      = '0;
        row_base_d = row_base_q + ADDR_W'(IMG_W);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Address generator and frame-ready latch registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b0;
      row_base_q <= '0;
      col_q      <= '0;
      pix_addr_q <= '0;
    end else begin
      ready_q    <= ready_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      pix_addr_q <= pix_addr_d;
    end
  end

  // Control delay line: slot RD_LAT lines up with the pix_data answering this pixel's address.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= RD_LAT; i++) dl_q[i] <= STAGE_IDLE;
    end else begin
      dl_q[0] <= stage0;
      for (int i = 1; i <= RD_LAT; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  // Colour select: black in blanking, image sample inside a ready window, border elsewhere.
  always_comb begin
    grey_d = 8'h00;
    if (dl_q[RD_LAT].vis) grey_d = dl_q[RD_LAT].show ? pix_data : BORDER;
  end

  // Output register so sync, blank and colour leave on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      grey_q  <= 8'h00;
    end else begin
      hs_q    <= dl_q[RD_LAT].hs_n;
      vs_q    <= dl_q[RD_LAT].vs_n;
      blank_q <= dl_q[RD_LAT].vis;
      grey_q  <= grey_d;
    end
  end

  assign pix_addr    = pix_addr_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank   = blank_q;
  assign vga_clock   = ~clk;
  assign r_out       = grey_q;
  assign g_out       = grey_q;
  assign b_out       = grey_q;
  assign frame_start = fs;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Scoreboard bench: three scanners with read latency 1, 2 and 3 on a shrunken raster.
module tb_vga_frame_scanner;

  localparam int TH_VIS = 64, TH_FP = 4, TH_SYNC = 8, TH_BP = 4;
  localparam int TV_VIS = 48, TV_FP = 2, TV_SYNC = 2, TV_BP = 3;
  localparam int TH_TOT = TH_VIS + TH_FP + TH_SYNC + TH_BP;
  localparam int TV_TOT = TV_VIS + TV_FP + TV_SYNC + TV_BP;
  localparam int FRAME  = TH_TOT * TV_TOT;
  localparam int IMG_W  = 32, IMG_H = 24, X0 = 16, Y0 = 12;
  localparam logic [7:0] BORDER = 8'h5A;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
    logic [7:0] grey;
  } exp_t;

  localparam exp_t IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, grey: 8'h00};

  logic        clk;
  logic        reset;
  logic        frame_ready;
  logic [18:0] addr  [3];
  logic [7:0]  data  [3];
  logic        hs    [3];
  logic        vs    [3];
  logic        blank [3];
  logic        vclk  [3];
  logic [7:0]  r     [3];
  logic [7:0]  g     [3];
  logic [7:0]  b     [3];
  logic        fs    [3];

  int          errors = 0;
  int          checks = 0;

  bit          mact;
  int          mh, mv;
  bit          mready;
  logic [18:0] lastAddr;
  exp_t        hist[$];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    vga_frame_scanner #(
      .H_VIS (TH_VIS), .H_FP (TH_FP), .H_SYNC (TH_SYNC), .H_BP (TH_BP),
      .V_VIS (TV_VIS), .V_FP (TV_FP), .V_SYNC (TV_SYNC), .V_BP (TV_BP),
      .IMG_W (IMG_W), .IMG_H (IMG_H), .X0 (X0), .Y0 (Y0),
      .RD_LAT (k + 1), .BORDER (BORDER)
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_ready (frame_ready),
      .pix_addr    (addr[k]),
      .pix_data    (data[k]),
      .vga_hs      (hs[k]),
      .vga_vs      (vs[k]),
      .vga_blank   (blank[k]),
      .vga_clock   (vclk[k]),
      .r_out       (r[k]),
      .g_out       (g[k]),
      .b_out       (b[k]),
      .frame_start (fs[k])
    );

    // Memory model: returns addr[7:0] k+1 clocks after the address is presented.
    logic [7:0] latQ [k+1];
    always @(posedge clk) begin
      latQ[0] <= addr[k][7:0];
      for (int i = 1; i <= k; i++) latQ[i] <= latQ[i-1];
    end
    assign data[k] = latQ[k];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit model_in_win();
    return mact && mh >= X0 && mh < X0 + IMG_W && mv >= Y0 && mv < Y0 + IMG_H;
  endfunction

  function automatic logic [18:0] model_addr();
    return 19'((mv - Y0) * IMG_W + (mh - X0));
  endfunction

  function automatic exp_t model_entry();
    exp_t e;
    logic [18:0] a;
    e = IDLE;
    if (mact) begin
      e.hs    = !(mh >= TH_VIS + TH_FP && mh < TH_VIS + TH_FP + TH_SYNC);
      e.vs    = !(mv >= TV_VIS + TV_FP && mv < TV_VIS + TV_FP + TV_SYNC);
      e.blank = (mh < TH_VIS) && (mv < TV_VIS);
      if (e.blank) begin
        a      = model_addr();
        e.grey = (model_in_win() && mready) ? a[7:0] : BORDER;
      end
    end
    return e;
  endfunction

  // One clock: push the expected pixel, advance, compare every output against the scoreboard.
  task automatic cycle();
    exp_t        e, x;
    logic [18:0] ea;
    bit          efs, rst, rdy;
    e   = model_entry();
    efs = mact && mh == 0 && mv == 0;
    rst = reset;
    rdy = frame_ready;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fs[k] !== efs) begin
        errors++;
        $display("[TB] FAIL frame_start inst%0d at (%0d,%0d): got %b expected %b", k, mh, mv, fs[k], efs);
      end
    end
    if (rst)                 ea = '0;
    else if (model_in_win()) ea = model_addr();
    else                     ea = lastAddr;
    lastAddr = ea;
    @(posedge clk);
    #1;
    if (rst) begin
      mact = 0; mh = 0; mv = 0; mready = 0;
      hist.delete();
      repeat (5) hist.push_back(IDLE);
    end else begin
      hist.push_back(e);
      if (hist.size() > 5) void'(hist.pop_front());
      if (!mact) begin
        mact = 1;
      end else begin
        if (efs) mready = rdy;
        mh++;
        if (mh == TH_TOT) begin
          mh = 0;
          mv++;
          if (mv == TV_TOT) mv = 0;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      x = hist[hist.size() - (k + 3)];
      checks++;
      if (addr[k] !== ea) begin
        errors++;
        $display("[TB] FAIL pix_addr inst%0d: got %0d expected %0d", k, addr[k], ea);
      end
      checks++;
      if (hs[k] !== x.hs) begin
        errors++;
        $display("[TB] FAIL vga_hs inst%0d: got %b expected %b", k, hs[k], x.hs);
      end
      checks++;
      if (vs[k] !== x.vs) begin
        errors++;
        $display("[TB] FAIL vga_vs inst%0d: got %b expected %b", k, vs[k], x.vs);
      end
      checks++;
      if (blank[k] !== x.blank) begin
        errors++;
        $display("[TB] FAIL vga_blank inst%0d: got %b expected %b", k, blank[k], x.blank);
      end
      checks++;
      if ({r[k], g[k], b[k]} !== {x.grey, x.grey, x.grey}) begin
        errors++;
        $display("[TB] FAIL rgb inst%0d: got %h/%h/%h expected %h", k, r[k], g[k], b[k], x.grey);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (5) begin
      cycle();
      checks++;
      if (addr[0] !== 19'd0 || hs[0] !== 1'b1 || vs[0] !== 1'b1 || blank[0] !== 1'b0 || r[0] !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_values: got addr=%0d hs=%b vs=%b blank=%b r=%h expected 0/1/1/0/00",
                 addr[0], hs[0], vs[0], blank[0], r[0]);
      end
    end
    checks++;
    if (vclk[0] !== ~clk) begin
      errors++;
      $display("[TB] FAIL vga_clock: got %b expected %b", vclk[0], ~clk);
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (fs[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_frame_start: got %b expected 1", fs[0]);
    end
    n = 0;
    do begin
      cycle();
      n++;
    end while (fs[0] !== 1'b1 && n < 2 * FRAME);
    checks++;
    if (n != FRAME) begin
      errors++;
      $display("[TB] FAIL frame_period: got %0d expected %0d", n, FRAME);
    end
  endtask

  task automatic test_line_timing();
    int n, hsLow, blankHigh;
    n = 0;
    while (!(mact && mh == 0 && mv == 1) && n < 2 * FRAME) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 2 * FRAME) begin
      errors++;
      $display("[TB] FAIL line_wait: got timeout expected line 1 start");
    end
    hsLow = 0;
    blankHigh = 0;
    repeat (TH_TOT) begin
      cycle();
      if (hs[0] === 1'b0) hsLow++;
      if (blank[0] === 1'b1) blankHigh++;
    end
    checks++;
    if (hsLow != TH_SYNC) begin
      errors++;
      $display("[TB] FAIL hs_width: got %0d expected %0d", hsLow, TH_SYNC);
    end
    checks++;
    if (blankHigh != TH_VIS) begin
      errors++;
      $display("[TB] FAIL blank_width: got %0d expected %0d", blankHigh, TH_VIS);
    end
  endtask

  task automatic test_ready_gating();
    int n;
    int shown [3];
    frame_ready = 1'b0;
    n = 0;
    while (!(mact && mh == 0 && mv == 0) && n < 2 * FRAME) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 2 * FRAME) begin
      errors++;
      $display("[TB] FAIL ready_wait: got timeout expected frame start");
    end
    for (int k = 0; k < 3; k++) shown[k] = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == FRAME / 2) frame_ready = 1'b1;
      cycle();
      for (int k = 0; k < 3; k++) if (blank[k] === 1'b1 && r[k] !== BORDER) shown[k]++;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (shown[k] != 0) begin
        errors++;
        $display("[TB] FAIL gated_frame inst%0d: got %0d image pixels expected 0", k, shown[k]);
      end
      shown[k] = 0;
    end
    repeat (FRAME) begin
      cycle();
      for (int k = 0; k < 3; k++) if (blank[k] === 1'b1 && r[k] !== BORDER) shown[k]++;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (shown[k] != IMG_W * IMG_H - 3) begin
        errors++;
        $display("[TB] FAIL ready_frame inst%0d: got %0d image pixels expected %0d", k, shown[k], IMG_W * IMG_H - 3);
      end
    end
  endtask

  task automatic test_address();
    int ph, pv, vsLow;
    logic [18:0] maxAddr;
    maxAddr = '0;
    vsLow = 0;
    repeat (FRAME) begin
      ph = mh;
      pv = mv;
      cycle();
      if (addr[0] > maxAddr) maxAddr = addr[0];
      if (vs[0] === 1'b0) vsLow++;
      if (ph == X0 && pv == Y0) begin
        checks++;
        if (addr[0] !== 19'd0) begin
          errors++;
          $display("[TB] FAIL addr_origin: got %0d expected 0", addr[0]);
        end
      end
      if (ph == X0 + IMG_W - 1 && pv == Y0) begin
        checks++;
        if (addr[0] !== 19'(IMG_W - 1)) begin
          errors++;
          $display("[TB] FAIL addr_row0_end: got %0d expected %0d", addr[0], IMG_W - 1);
        end
      end
      if (ph == X0 && pv == Y0 + 1) begin
        checks++;
        if (addr[0] !== 19'(IMG_W)) begin
          errors++;
          $display("[TB] FAIL addr_row1_start: got %0d expected %0d", addr[0], IMG_W);
        end
      end
    end
    checks++;
    if (maxAddr !== 19'(IMG_W * IMG_H - 1)) begin
      errors++;
      $display("[TB] FAIL addr_max: got %0d expected %0d", maxAddr, IMG_W * IMG_H - 1);
    end
    checks++;
    if (vsLow != TV_SYNC * TH_TOT) begin
      errors++;
      $display("[TB] FAIL vs_width: got %0d expected %0d", vsLow, TV_SYNC * TH_TOT);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    while (!(mact && mh == 40 && mv == 20) && n < 2 * FRAME) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 2 * FRAME) begin
      errors++;
      $display("[TB] FAIL mid_reset_wait: got timeout expected (40,20)");
    end
    reset = 1'b1;
    cycle();
    checks++;
    if (addr[0] !== 19'd0 || hs[0] !== 1'b1 || vs[0] !== 1'b1 || blank[0] !== 1'b0 || r[0] !== 8'h00 || fs[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_values: got addr=%0d hs=%b vs=%b blank=%b r=%h fs=%b expected 0/1/1/0/00/0",
               addr[0], hs[0], vs[0], blank[0], r[0], fs[0]);
    end
    reset = 1'b0;
    cycle();
    checks++;
    if (fs[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_frame_start: got %b expected 1", fs[0]);
    end
    repeat (FRAME + 10) cycle();
  endtask

  initial begin
    reset = 1'b1;
    frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mact = 0; mh = 0; mv = 0; mready = 0;
    lastAddr = '0;
    repeat (5) hist.push_back(IDLE);
    test_reset();
    test_line_timing();
    test_ready_gating();
    test_address();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
